// File: rtl/polirv_mc_ctrl.sv
// polirv_mc_ctrl: multicycle control FSM for the polirv core (LD, SD, ADDI, ADD, SUB, BEQ/BNE/BLT/BGE).
// Optional performance counters are built only when the PERF_CNT_EN macro is defined.
module polirv_mc_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_BITS    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_5,
   input  logic [3:0]          alu_flags,
   output logic                i_mem_req,
   input  logic                i_mem_ack,
   output logic                d_mem_req,
   output logic                d_mem_we,
   input  logic                d_mem_ack,
   output logic                ir_we,
   output logic                pc_we,
   output logic                pc_src,
   output logic                rf_we,
   output logic                rf_src,
   output logic                alu_src,
   output logic [3:0]          alu_cmd,
   output logic                halted,
   output logic [1:0]          err_code,
   output logic [CNT_BITS-1:0] cycle_cnt,
   output logic [CNT_BITS-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StTrap
   } state_e;

   typedef enum logic [2:0] {
      OpLd,
      OpSd,
      OpAddi,
      OpAdd,
      OpSub,
      OpBr
   } op_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_IMEM    = 2'b10;
   localparam logic [1:0] ERR_DMEM    = 2'b11;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   op_e        op_q, op_d;
   logic [2:0] br_f3_q, br_f3_d;
   logic [7:0] wait_q, wait_d;
   logic [1:0] err_q, err_d;

   logic flag_v, flag_n, flag_z;
   logic unused_carry;

   assign flag_v       = alu_flags[3];
   assign flag_n       = alu_flags[1];
   assign flag_z       = alu_flags[0];
   assign unused_carry = alu_flags[2];

   // Instruction decode, sampled in DECODE while fd holds the fetched IR.
   op_e  dec_op;
   logic dec_legal;

   always_comb begin
      dec_op    = OpAdd;
      dec_legal = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            dec_op    = OpLd;
            dec_legal = (funct3 == 3'b011);
         end
         OPC_STORE: begin
            dec_op    = OpSd;
            dec_legal = (funct3 == 3'b011);
         end
         OPC_OPIMM: begin
            dec_op    = OpAddi;
            dec_legal = (funct3 == 3'b000);
         end
         OPC_OP: begin
            dec_op    = funct7_5 ? OpSub : OpAdd;
            dec_legal = (funct3 == 3'b000);
         end
         OPC_BRANCH: begin
            dec_op    = OpBr;
            dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
         end
         default: begin
            dec_op    = OpAdd;
            dec_legal = 1'b0;
         end
      endcase
   end

   logic taken;

   always_comb begin
      taken = 1'b0;
      case (br_f3_q)
         3'b000:  taken = flag_z;
         3'b001:  taken = !flag_z;
         3'b100:  taken = flag_n ^ flag_v;
         3'b101:  taken = !(flag_n ^ flag_v);
         default: taken = 1'b0;
      endcase
   end

   // ALU setup is held from EXEC through MEM/WB so fd sees a stable result.
   logic [3:0] op_alu_cmd;
   logic       op_alu_src;

   assign op_alu_cmd = ((op_q == OpSub) || (op_q == OpBr)) ? ALU_SUB : ALU_ADD;
   assign op_alu_src = (op_q == OpLd) || (op_q == OpSd) || (op_q == OpAddi);

   logic mem_wait;
   logic wait_at_limit;

   assign mem_wait      = ((state_q == StFetch) && !i_mem_ack) ||
                          ((state_q == StMem) && !d_mem_ack);
   assign wait_at_limit = (wait_q == WAIT_LIMIT);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      br_f3_d   = br_f3_q;
      err_d     = err_q;
      i_mem_req = 1'b0;
      d_mem_req = 1'b0;
      d_mem_we  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      rf_we     = 1'b0;
      rf_src    = 1'b0;
      alu_src   = 1'b0;
      alu_cmd   = 4'b0000;

      unique case (state_q)
         StFetch: begin
            i_mem_req = 1'b1;
            ir_we     = i_mem_ack;
            if (i_mem_ack) begin
               state_d = StDecode;
            end else if (wait_at_limit) begin
               state_d = StTrap;
               err_d   = ERR_IMEM;
            end
         end
         StDecode: begin
            if (dec_legal) begin
               state_d = StExec;
               op_d    = dec_op;
               br_f3_d = funct3;
            end else begin
               state_d = StTrap;
               err_d   = ERR_ILLEGAL;
            end
         end
         StExec: begin
            alu_cmd = op_alu_cmd;
            alu_src = op_alu_src;
            if (op_q == OpBr) begin
               pc_we   = 1'b1;
               pc_src  = taken;
               state_d = StFetch;
            end else if ((op_q == OpLd) || (op_q == OpSd)) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            alu_cmd   = op_alu_cmd;
            alu_src   = op_alu_src;
            d_mem_req = 1'b1;
            d_mem_we  = (op_q == OpSd);
            if (d_mem_ack) begin
               if (op_q == OpSd) begin
                  pc_we   = 1'b1;
                  state_d = StFetch;
               end else begin
                  rf_we   = 1'b1;
                  rf_src  = 1'b1;
                  state_d = StWb;
               end
            end else if (wait_at_limit) begin
               state_d = StTrap;
               err_d   = ERR_DMEM;
            end
         end
         StWb: begin
            alu_cmd = op_alu_cmd;
            alu_src = op_alu_src;
            rf_we   = (op_q != OpLd);
            pc_we   = 1'b1;
            state_d = StFetch;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StTrap;
            err_d   = ERR_ILLEGAL;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = 8'd0;
      end else if (mem_wait) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         op_q    <= OpAdd;
         br_f3_q <= 3'b000;
         wait_q  <= 8'd0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         br_f3_q <= br_f3_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   assign halted   = (state_q == StTrap);
   assign err_code = err_q;

`ifdef PERF_CNT_EN
   logic [CNT_BITS-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_BITS-1:0] instret_cnt_q, instret_cnt_d;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      instret_cnt_d = instret_cnt_q;
      if (state_q != StTrap) begin
         cycle_cnt_d = cycle_cnt_q + 1'b1;
      end
      if (pc_we) begin
         instret_cnt_d = instret_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_polirv_mc_ctrl.sv
// Directed bench for polirv_mc_ctrl; counter checks follow the PERF_CNT_EN macro.
module tb_polirv_mc_ctrl;
   localparam int unsigned CNT_BITS = 32;

`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Control vector bit masks: {i_req,d_req,d_we,ir_we,pc_we,pc_src,rf_we,rf_src,alu_src,alu_cmd}
   localparam logic [12:0] I_REQ   = 13'h1000;
   localparam logic [12:0] D_REQ   = 13'h0800;
   localparam logic [12:0] D_WE    = 13'h0400;
   localparam logic [12:0] IR_WE   = 13'h0200;
   localparam logic [12:0] PC_WE   = 13'h0100;
   localparam logic [12:0] PC_SRC  = 13'h0080;
   localparam logic [12:0] RF_WE   = 13'h0040;
   localparam logic [12:0] RF_SRC  = 13'h0020;
   localparam logic [12:0] ALU_SRC = 13'h0010;
   localparam logic [12:0] ADD     = 13'h0002;
   localparam logic [12:0] SUB     = 13'h0006;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [6:0]          opcode = '0;
   logic [2:0]          funct3 = '0;
   logic                funct7_5 = 1'b0;
   logic [3:0]          alu_flags = '0;
   logic                i_mem_ack = 1'b0;
   logic                d_mem_ack = 1'b0;
   logic                i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, pc_src;
   logic                rf_we, rf_src, alu_src, halted;
   logic [3:0]          alu_cmd;
   logic [1:0]          err_code;
   logic [CNT_BITS-1:0] cycle_cnt, instret_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   polirv_mc_ctrl #(
      .MEM_TIMEOUT(4),
      .CNT_BITS   (CNT_BITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .alu_flags  (alu_flags),
      .i_mem_req  (i_mem_req),
      .i_mem_ack  (i_mem_ack),
      .d_mem_req  (d_mem_req),
      .d_mem_we   (d_mem_we),
      .d_mem_ack  (d_mem_ack),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .rf_we      (rf_we),
      .rf_src     (rf_src),
      .alu_src    (alu_src),
      .alu_cmd    (alu_cmd),
      .halted     (halted),
      .err_code   (err_code),
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   wire [12:0] ctl = {i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, pc_src, rf_we, rf_src,
                      alu_src, alu_cmd};

   function automatic logic [CNT_BITS-1:0] exp_cnt(input int v);
      return PERF ? CNT_BITS'(v) : '0;
   endfunction

   task automatic set_ir(input logic [31:0] ir);
      opcode   = ir[6:0];
      funct3   = ir[14:12];
      funct7_5 = ir[30];
   endtask

   // Advance to the middle of the next cycle, drive acks, let outputs settle.
   task automatic cyc(input logic ia, input logic da);
      @(negedge clk);
      i_mem_ack = ia;
      d_mem_ack = da;
      #1;
   endtask

   // Leaves time just after the reset edge, inside cycle 1 (FETCH).
   task automatic apply_reset();
      @(negedge clk);
      rst       = 1'b1;
      i_mem_ack = 1'b0;
      d_mem_ack = 1'b0;
      alu_flags = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (ctl !== I_REQ) begin
         $display("FAIL reset_ctl: got %h want %h", ctl, I_REQ);
         n_bad++;
      end
      n_cmp++;
      if ({halted, err_code} !== 3'b000) begin
         $display("FAIL reset_status: got %b want 000", {halted, err_code});
         n_bad++;
      end
      n_cmp++;
      if ({cycle_cnt, instret_cnt} !== {CNT_BITS'(0), CNT_BITS'(0)}) begin
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
         n_bad++;
      end
   endtask

   task automatic test_add();
      logic [12:0] exp [5] = '{I_REQ | IR_WE, 13'h0, ADD, RF_WE | PC_WE | ADD, I_REQ};
      apply_reset();
      set_ir(32'h00B50533);
      for (int i = 0; i < 5; i++) begin
         cyc(i == 0, 1'b0);
         n_cmp++;
         if (ctl !== exp[i]) begin
            $display("FAIL add_c%0d: got %h want %h", i + 1, ctl, exp[i]);
            n_bad++;
         end
      end
      n_cmp++;
      if (cycle_cnt !== exp_cnt(4) || instret_cnt !== exp_cnt(1)) begin
         $display("FAIL add_cnt: got %0d/%0d want %0d/%0d", cycle_cnt, instret_cnt,
                  exp_cnt(4), exp_cnt(1));
         n_bad++;
      end
   endtask

   task automatic test_load_slow();
      logic [12:0] exp [9] = '{I_REQ | IR_WE, 13'h0, ALU_SRC | ADD,
                               D_REQ | ALU_SRC | ADD, D_REQ | ALU_SRC | ADD,
                               D_REQ | ALU_SRC | ADD,
                               D_REQ | RF_WE | RF_SRC | ALU_SRC | ADD,
                               PC_WE | ALU_SRC | ADD, I_REQ};
      apply_reset();
      set_ir(32'h00053583);
      for (int i = 0; i < 9; i++) begin
         cyc(i == 0, i == 6);
         n_cmp++;
         if (ctl !== exp[i]) begin
            $display("FAIL ld_c%0d: got %h want %h", i + 1, ctl, exp[i]);
            n_bad++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] exp [9] = '{I_REQ | IR_WE, 13'h0, ALU_SRC | ADD,
                               D_REQ | D_WE | PC_WE | ALU_SRC | ADD,
                               I_REQ | IR_WE, 13'h0, ALU_SRC | ADD,
                               RF_WE | PC_WE | ALU_SRC | ADD, I_REQ};
      apply_reset();
      set_ir(32'h00B53023);
      for (int i = 0; i < 9; i++) begin
         if (i == 4) set_ir(32'h00150513);
         cyc(i == 0 || i == 4, i == 3);
         n_cmp++;
         if (ctl !== exp[i]) begin
            $display("FAIL sd_addi_c%0d: got %h want %h", i + 1, ctl, exp[i]);
            n_bad++;
         end
      end
      n_cmp++;
      if (cycle_cnt !== exp_cnt(8) || instret_cnt !== exp_cnt(2)) begin
         $display("FAIL sd_addi_cnt: got %0d/%0d want %0d/%0d", cycle_cnt, instret_cnt,
                  exp_cnt(8), exp_cnt(2));
         n_bad++;
      end
   endtask

   task automatic test_branch();
      logic [31:0] irs [6] = '{32'h00B50463, 32'h00B50463, 32'h00B51463,
                               32'h00B54463, 32'h00B55463, 32'h00B54463};
      logic [3:0]  flg [6] = '{4'b0001, 4'b0100, 4'b0000, 4'b1010, 4'b1010, 4'b0010};
      logic        tkn [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [12:0] exp;
      apply_reset();
      for (int b = 0; b < 6; b++) begin
         set_ir(irs[b]);
         cyc(1'b1, 1'b0);
         n_cmp++;
         if (ctl !== (I_REQ | IR_WE)) begin
            $display("FAIL br%0d_fetch: got %h want %h", b, ctl, I_REQ | IR_WE);
            n_bad++;
         end
         cyc(1'b0, 1'b0);
         alu_flags = flg[b];
         cyc(1'b0, 1'b0);
         exp = PC_WE | SUB | (tkn[b] ? PC_SRC : 13'h0);
         n_cmp++;
         if (ctl !== exp) begin
            $display("FAIL br%0d_exec: got %h want %h", b, ctl, exp);
            n_bad++;
         end
      end
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (ctl !== I_REQ || cycle_cnt !== exp_cnt(18) || instret_cnt !== exp_cnt(6)) begin
         $display("FAIL br_after: got %h %0d/%0d want %h %0d/%0d", ctl, cycle_cnt,
                  instret_cnt, I_REQ, exp_cnt(18), exp_cnt(6));
         n_bad++;
      end
   endtask

   task automatic test_illegal();
      logic [31:0] irs [2] = '{32'h0000007F, 32'h00052583};
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         set_ir(irs[k]);
         cyc(1'b1, 1'b0);
         cyc(1'b0, 1'b0);
         n_cmp++;
         if ({ctl, halted} !== 14'h0) begin
            $display("FAIL ill%0d_decode: got %h want 0", k, {ctl, halted});
            n_bad++;
         end
         for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'b1);
            n_cmp++;
            if ({ctl, halted, err_code} !== {13'h0, 1'b1, 2'b01}) begin
               $display("FAIL ill%0d_trap_c%0d: got %h/%b/%b want 0/1/01", k, c, ctl, halted,
                        err_code);
               n_bad++;
            end
         end
         n_cmp++;
         if (cycle_cnt !== exp_cnt(2) || instret_cnt !== exp_cnt(0)) begin
            $display("FAIL ill%0d_cnt: got %0d/%0d want %0d/0", k, cycle_cnt, instret_cnt,
                     exp_cnt(2));
            n_bad++;
         end
      end
   endtask

   task automatic test_timeout();
      // Fetch never acked: five FETCH cycles (wait 0..4), then TRAP.
      apply_reset();
      set_ir(32'h00B50533);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0);
         n_cmp++;
         if ({ctl, halted} !== {I_REQ, 1'b0}) begin
            $display("FAIL ito_wait%0d: got %h want %h", i, {ctl, halted}, {I_REQ, 1'b0});
            n_bad++;
         end
      end
      cyc(1'b1, 1'b1);
      n_cmp++;
      if ({ctl, halted, err_code} !== {13'h0, 1'b1, 2'b10}) begin
         $display("FAIL ito_trap: got %h/%b/%b want 0/1/10", ctl, halted, err_code);
         n_bad++;
      end
      // Ack arrives exactly when the count hits the limit: accepted.
      apply_reset();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      n_cmp++;
      if (ctl !== (I_REQ | IR_WE)) begin
         $display("FAIL ito_late_ack: got %h want %h", ctl, I_REQ | IR_WE);
         n_bad++;
      end
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({ctl, halted, err_code} !== 16'h0) begin
         $display("FAIL ito_no_trap: got %h/%b/%b want 0/0/00", ctl, halted, err_code);
         n_bad++;
      end
      // Data side never acked.
      apply_reset();
      set_ir(32'h00053583);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0);
         n_cmp++;
         if ({ctl, halted} !== {D_REQ | ALU_SRC | ADD, 1'b0}) begin
            $display("FAIL dto_wait%0d: got %h want %h", i, {ctl, halted},
                     {D_REQ | ALU_SRC | ADD, 1'b0});
            n_bad++;
         end
      end
      cyc(1'b0, 1'b0);
      n_cmp++;
      if ({ctl, halted, err_code} !== {13'h0, 1'b1, 2'b11}) begin
         $display("FAIL dto_trap: got %h/%b/%b want 0/1/11", ctl, halted, err_code);
         n_bad++;
      end
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (cycle_cnt !== exp_cnt(8) || instret_cnt !== exp_cnt(0)) begin
         $display("FAIL dto_cnt: got %0d/%0d want %0d/0", cycle_cnt, instret_cnt, exp_cnt(8));
         n_bad++;
      end
   endtask

   task automatic test_reset_mid_mem();
      apply_reset();
      set_ir(32'h00B53023);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (ctl !== (D_REQ | D_WE | ALU_SRC | ADD) || cycle_cnt !== exp_cnt(3)) begin
         $display("FAIL rmm_mem: got %h %0d want %h %0d", ctl, cycle_cnt,
                  D_REQ | D_WE | ALU_SRC | ADD, exp_cnt(3));
         n_bad++;
      end
      // Reset coincides with the data ack; reset must win.
      @(negedge clk);
      rst       = 1'b1;
      d_mem_ack = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      d_mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== I_REQ || {halted, err_code} !== 3'b000) begin
         $display("FAIL rmm_fetch: got %h/%b want %h/000", ctl, {halted, err_code}, I_REQ);
         n_bad++;
      end
      n_cmp++;
      if (cycle_cnt !== exp_cnt(0) || instret_cnt !== exp_cnt(0)) begin
         $display("FAIL rmm_cnt: got %0d/%0d want 0/0", cycle_cnt, instret_cnt);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_slow();
      test_back_to_back();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
